dmi_jtag: RTL and testbench

DMI_JTAG -- requirements
Module: dmi_jtag

---
 rtl/dmi_jtag_pkg.sv | 50 +++++
 rtl/dmi_jtag_if.sv | 14 +
 rtl/dmi_jtag_tap.sv | 123 ++++++++++++
 rtl/dmi_jtag.sv | 148 ++++++++++++++
 tb/tb_dmi_jtag.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dmi_jtag_pkg.sv
// Shared types for the JTAG debug transport: DMI request/response, DTM op codes,
// TAP and DMI state encodings, instruction codes and the DTMCS capture image.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;
    localparam logic [1:0] DTM_BUSY    = 2'd3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [3:0] {
        TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
        SH_DR    = 4'd4,  EX1_DR   = 4'd5,  PAUSE_DR = 4'd6,  EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SH_IR    = 4'd11,
        EX1_IR   = 4'd12, PAUSE_IR = 4'd13, EX2_IR   = 4'd14, UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        DMI_IDLE       = 3'd0,
        DMI_READ       = 3'd1,
        DMI_WAIT_READ  = 3'd2,
        DMI_WRITE      = 3'd3,
        DMI_WAIT_WRITE = 3'd4
    } dmi_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    // idle count 1, abits 7, version 0.13 (1); reset strobes always read back as 0
    function automatic logic [31:0] dtmcs_capture(input logic [1:0] dmistat);
        return {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'd7, 4'd1};
    endfunction

endpackage

// File: rtl/dmi_jtag_if.sv
// DMI bus bundle: master is the DTM issuing requests, slave is the debug module.
interface dmi_jtag_if;
    import dm::*;

    dmi_req_t  req;
    logic      req_valid;
    logic      req_ready;
    dmi_resp_t resp;
    logic      resp_valid;
    logic      resp_ready;

    modport master (output req, req_valid, resp_ready, input req_ready, resp, resp_valid);
    modport slave  (input req, req_valid, resp_ready, output req_ready, resp, resp_valid);
endinterface

// File: rtl/dmi_jtag_tap.sv
// IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers and TDO mux;
// everything runs in the clk domain, stepping on synchronised TCK strobes.
module dmi_jtag_tap
    import dm::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0DB3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tck_rise,
    input  logic       tck_fall,
    input  logic       tms,
    input  logic       tdi,
    input  logic       trst_n,
    input  logic       dr_tdo,
    output logic [4:0] ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       td_o,
    output logic       tdo_oe_o
);

    tap_state_e  state_r, state_next;
    logic [4:0]  ir_sr_r;
    logic [31:0] idcode_sr_r;
    logic        bypass_r;
    logic        tdo_s;
    logic        capture_ir, shift_ir, update_ir;

    assign capture_dr = tck_rise & (state_r == CAP_DR);
    assign shift_dr   = tck_rise & (state_r == SH_DR);
    assign update_dr  = tck_rise & (state_r == UPD_DR);
    assign capture_ir = tck_rise & (state_r == CAP_IR);
    assign shift_ir   = tck_rise & (state_r == SH_IR);
    assign update_ir  = tck_rise & (state_r == UPD_IR);

    // TAP state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= TLR;
        else     state_r <= state_next;
    end

    // TAP next-state: TRST wins, otherwise step on each TCK rise
    always_comb begin
        state_next = state_r;
        if (!trst_n) begin
            state_next = TLR;
        end else if (tck_rise) begin
            case (state_r)
                TLR:      state_next = tms ? TLR    : RTI;
                RTI:      state_next = tms ? SEL_DR : RTI;
                SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
                CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
                SH_DR:    state_next = tms ? EX1_DR : SH_DR;
                EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
                UPD_DR:   state_next = tms ? SEL_DR : RTI;
                SEL_IR:   state_next = tms ? TLR    : CAP_IR;
                CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
                SH_IR:    state_next = tms ? EX1_IR : SH_IR;
                EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
                UPD_IR:   state_next = tms ? SEL_DR : RTI;
                default:  state_next = TLR;
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // Instruction register and the TAP-local data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir          <= IR_IDCODE;
            ir_sr_r     <= 5'd0;
            idcode_sr_r <= 32'd0;
            bypass_r    <= 1'b0;
        end else begin
            if (state_r == TLR) ir <= IR_IDCODE;
            else if (update_ir) ir <= ir_sr_r;
            if (capture_ir)    ir_sr_r <= 5'b00101;
            else if (shift_ir) ir_sr_r <= {tdi, ir_sr_r[4:1]};
            if (capture_dr) begin
                idcode_sr_r <= IDCODE_VALUE;
                bypass_r    <= 1'b0;
            end else if (shift_dr) begin
                idcode_sr_r <= {tdi, idcode_sr_r[31:1]};
                bypass_r    <= tdi;
            end
        end
    end

    // Select the LSB of whichever register is being shifted
    always_comb begin
        tdo_s = 1'b0;
        if (state_r == SH_IR) begin
            tdo_s = ir_sr_r[0];
        end else if (state_r == SH_DR) begin
            case (ir)
                IR_IDCODE:        tdo_s = idcode_sr_r[0];
                IR_DTMCS, IR_DMI: tdo_s = dr_tdo;
                default:          tdo_s = bypass_r;
            endcase
        end else begin
            tdo_s = 1'b0;
        end
    end

    // TDO and its enable change on the TCK fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            td_o     <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else if (tck_fall) begin
            td_o     <= tdo_s;
            tdo_oe_o <= (state_r == SH_IR) || (state_r == SH_DR);
        end
    end

endmodule

// File: rtl/dmi_jtag.sv
// JTAG debug transport module: synchronises the JTAG pins, hosts DTMCS and
// DMIACCESS and runs the DMI request/response FSM toward the debug module.
module dmi_jtag
    import dm::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0DB3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tck_i,
    input  logic      tms_i,
    input  logic      td_i,
    input  logic      trst_ni,
    output logic      td_o,
    output logic      tdo_oe_o,
    output logic      dbg_dmi_clear_o,
    output dmi_req_t  dbg_dmi_req_o,
    output logic      dbg_dmi_req_valid_o,
    input  logic      dbg_dmi_req_ready_i,
    input  dmi_resp_t dbg_dmi_resp_i,
    input  logic      dbg_dmi_resp_valid_i,
    output logic      dbg_dmi_resp_ready_o
);

    logic [3:0]  sync1_r, sync2_r;
    logic        tck_prev_r, tck_rise, tck_fall;
    logic [4:0]  ir;
    logic        capture_dr, shift_dr, update_dr, dr_tdo;
    logic [31:0] dtmcs_sr_r;
    logic [40:0] dmi_sr_r;
    logic [6:0]  addr_r;
    logic [31:0] data_r;
    dtm_op_e     op_r;
    logic [1:0]  err_r, status;
    dmi_state_e  dmi_state_r, dmi_state_next;
    logic        dtmcs_sel, dmi_sel, dmi_go, dtmcs_abort, dtmcs_clr, in_wait;

    // Two-flop synchronisers for {tck, tms, tdi, trst_n}; TRST starts asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= 4'b0100;
            sync2_r    <= 4'b0100;
            tck_prev_r <= 1'b0;
        end else begin
            sync1_r    <= {tck_i, tms_i, td_i, trst_ni};
            sync2_r    <= sync1_r;
            tck_prev_r <= sync2_r[3];
        end
    end

    assign tck_rise = sync2_r[3] & ~tck_prev_r;
    assign tck_fall = ~sync2_r[3] & tck_prev_r;

    dmi_jtag_tap #(.IDCODE_VALUE(IDCODE_VALUE)) u_tap (
        .clk        (clk),
        .rst        (rst),
        .tck_rise   (tck_rise),
        .tck_fall   (tck_fall),
        .tms        (sync2_r[2]),
        .tdi        (sync2_r[1]),
        .trst_n     (sync2_r[0]),
        .dr_tdo     (dr_tdo),
        .ir         (ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .td_o       (td_o),
        .tdo_oe_o   (tdo_oe_o)
    );

    assign dtmcs_sel   = (ir == IR_DTMCS);
    assign dmi_sel     = (ir == IR_DMI);
    assign dr_tdo      = dmi_sel ? dmi_sr_r[0] : dtmcs_sr_r[0];
    assign in_wait     = (dmi_state_r == DMI_WAIT_READ) || (dmi_state_r == DMI_WAIT_WRITE);
    assign status      = (dmi_state_r != DMI_IDLE) ? DTM_BUSY : err_r;
    assign dtmcs_abort = update_dr & dtmcs_sel & dtmcs_sr_r[17];
    assign dtmcs_clr   = update_dr & dtmcs_sel & (dtmcs_sr_r[16] | dtmcs_sr_r[17]);
    assign dmi_go      = update_dr & dmi_sel & (err_r == DTM_SUCCESS) & (dmi_state_r == DMI_IDLE)
                         & ((dmi_sr_r[1:0] == 2'd1) | (dmi_sr_r[1:0] == 2'd2));

    // DTMCS and DMIACCESS capture/shift registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dtmcs_sr_r <= 32'd0;
            dmi_sr_r   <= 41'd0;
        end else begin
            if (capture_dr && dtmcs_sel)    dtmcs_sr_r <= dtmcs_capture(err_r);
            else if (shift_dr && dtmcs_sel) dtmcs_sr_r <= {sync2_r[1], dtmcs_sr_r[31:1]};
            if (capture_dr && dmi_sel)      dmi_sr_r <= {addr_r, data_r, status};
            else if (shift_dr && dmi_sel)   dmi_sr_r <= {sync2_r[1], dmi_sr_r[40:1]};
        end
    end

    // DMI FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dmi_state_r <= DMI_IDLE;
        else     dmi_state_r <= dmi_state_next;
    end

    // DMI FSM next-state; a DTMCS hard reset overrides everything
    always_comb begin
        dmi_state_next = dmi_state_r;
        case (dmi_state_r)
            DMI_IDLE: begin
                if (dmi_go) dmi_state_next = (dmi_sr_r[1:0] == 2'd1) ? DMI_READ : DMI_WRITE;
                else        dmi_state_next = DMI_IDLE;
            end
            DMI_READ:       dmi_state_next = dbg_dmi_req_ready_i  ? DMI_WAIT_READ  : DMI_READ;
            DMI_WRITE:      dmi_state_next = dbg_dmi_req_ready_i  ? DMI_WAIT_WRITE : DMI_WRITE;
            DMI_WAIT_READ:  dmi_state_next = dbg_dmi_resp_valid_i ? DMI_IDLE       : DMI_WAIT_READ;
            DMI_WAIT_WRITE: dmi_state_next = dbg_dmi_resp_valid_i ? DMI_IDLE       : DMI_WAIT_WRITE;
            default:        dmi_state_next = DMI_IDLE;
        endcase
        if (dtmcs_abort) dmi_state_next = DMI_IDLE;
        else             dmi_state_next = dmi_state_next;
    end

    // Request latches, read data, sticky error and the clear pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r          <= 7'd0;
            data_r          <= 32'd0;
            op_r            <= DTM_NOP;
            err_r           <= DTM_SUCCESS;
            dbg_dmi_clear_o <= 1'b0;
        end else begin
            dbg_dmi_clear_o <= dtmcs_abort;
            if (dmi_go) begin
                addr_r <= dmi_sr_r[40:34];
                data_r <= dmi_sr_r[33:2];
                op_r   <= dtm_op_e'(dmi_sr_r[1:0]);
            end else if (dmi_state_r == DMI_WAIT_READ && dbg_dmi_resp_valid_i) begin
                data_r <= dbg_dmi_resp_i.data;
            end
            if (dtmcs_clr)
                err_r <= DTM_SUCCESS;
            else if (capture_dr && dmi_sel && dmi_state_r != DMI_IDLE)
                err_r <= DTM_BUSY;
            else if (in_wait && dbg_dmi_resp_valid_i && dbg_dmi_resp_i.resp != DTM_SUCCESS)
                err_r <= dbg_dmi_resp_i.resp;
        end
    end

    assign dbg_dmi_req_o        = {addr_r, op_r, data_r};
    assign dbg_dmi_req_valid_o  = (dmi_state_r == DMI_READ) || (dmi_state_r == DMI_WRITE);
    assign dbg_dmi_resp_ready_o = in_wait;

endmodule

// File: tb/tb_dmi_jtag.sv
// Directed bench for dmi_jtag: bit-bangs JTAG through the synchronisers and
// plays the debug-module side of the DMI bus by hand.
module tb_dmi_jtag;
    import dm::*;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst, tck, tms, tdi, trst_n;
    logic td_o, tdo_oe, dmi_clear;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   req_cnt = 0;
    int   clr_cnt = 0;
    logic [40:0] dout;
    logic [4:0]  irc;

    dmi_jtag_if dmi_bus ();

    dmi_jtag #(.IDCODE_VALUE(32'h0000_0DB3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .tck_i                (tck),
        .tms_i                (tms),
        .td_i                 (tdi),
        .trst_ni              (trst_n),
        .td_o                 (td_o),
        .tdo_oe_o             (tdo_oe),
        .dbg_dmi_clear_o      (dmi_clear),
        .dbg_dmi_req_o        (dmi_bus.req),
        .dbg_dmi_req_valid_o  (dmi_bus.req_valid),
        .dbg_dmi_req_ready_i  (dmi_bus.req_ready),
        .dbg_dmi_resp_i       (dmi_bus.resp),
        .dbg_dmi_resp_valid_i (dmi_bus.resp_valid),
        .dbg_dmi_resp_ready_o (dmi_bus.resp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmi_bus.req_valid && dmi_bus.req_ready) req_cnt <= req_cnt + 1;
        if (dmi_clear) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tdo_v = td_o;
        tms = tms_v;
        tdi = tdi_v;
        repeat (HALF) @(negedge clk);
        tck = 1'b1;
        repeat (HALF) @(negedge clk);
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tap_reset();
        logic b;
        repeat (5) tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic write_ir(input logic [4:0] v, output logic [4:0] cap);
        logic b;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, v[i], b);
            cap[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int n, input logic [40:0] din, output logic [40:0] dq);
        logic b;
        dq = 41'd0;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            if (i == 0) chk("tdo_oe_shift", {63'd0, tdo_oe}, 64'd1);
            tick(i == n - 1, din[i], b);
            dq[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic accept();
        @(negedge clk) dmi_bus.req_ready = 1'b1;
        @(negedge clk) dmi_bus.req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        @(negedge clk);
        dmi_bus.resp       = {d, r};
        dmi_bus.resp_valid = 1'b1;
        @(negedge clk) dmi_bus.resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
        dmi_bus.req_ready = 1'b0; dmi_bus.resp_valid = 1'b0; dmi_bus.resp = '0;
        repeat (3) @(negedge clk);
        chk("rst_td_o", {63'd0, td_o}, 64'd0);
        chk("rst_oe", {63'd0, tdo_oe}, 64'd0);
        chk("rst_req_valid", {63'd0, dmi_bus.req_valid}, 64'd0);
        chk("rst_resp_ready", {63'd0, dmi_bus.resp_ready}, 64'd0);
        chk("rst_clear", {63'd0, dmi_clear}, 64'd0);
        rst = 1'b0;
        tap_reset();

        scan_dr(32, 41'd0, dout);
        chk("idcode", dout, 64'h0DB3);

        write_ir(5'h11, irc);
        chk("ir_capture", irc, 64'h05);

        scan_dr(41, 41'h401FFFFF06, dout);
        chk("dmi_cap_reset", dout, 64'd0);
        chk("wr_req_valid", {63'd0, dmi_bus.req_valid}, 64'd1);
        chk("wr_req", dmi_bus.req, {7'h10, 2'd2, 32'h07FFFFC1});
        accept();
        repeat (4) @(negedge clk);
        chk("wr_resp_ready", {63'd0, dmi_bus.resp_ready}, 64'd1);
        chk("wr_valid_drop", {63'd0, dmi_bus.req_valid}, 64'd0);
        respond(32'd0, DTM_SUCCESS);
        chk("wr_resp_ready_drop", {63'd0, dmi_bus.resp_ready}, 64'd0);

        scan_dr(41, 41'h4000000001, dout);
        chk("cap_after_write", dout, {7'h10, 32'h07FFFFC1, 2'd0});
        chk("rd_req", dmi_bus.req, {7'h10, 2'd1, 32'h0});
        accept();
        respond(32'hCAFEBABE, DTM_SUCCESS);
        scan_dr(41, 41'd0, dout);
        chk("cap_read_data", dout, {7'h10, 32'hCAFEBABE, 2'd0});

        scan_dr(41, 41'h4000000001, dout);
        accept();
        scan_dr(41, 41'h4000000001, dout);
        chk("cap_busy", dout, {7'h10, 32'h0, 2'd3});
        respond(32'h12345678, DTM_SUCCESS);
        scan_dr(41, 41'h401FFFFF06, dout);
        chk("cap_sticky_busy", dout, {7'h10, 32'h12345678, 2'd3});
        chk("busy_no_req", {63'd0, dmi_bus.req_valid}, 64'd0);
        chk("busy_req_cnt", req_cnt, 64'd3);

        write_ir(5'h10, irc);
        scan_dr(32, 41'h10000, dout);
        chk("dtmcs_busy", dout, 64'h1C71);
        chk("dmireset_no_clear", clr_cnt, 64'd0);
        write_ir(5'h11, irc);
        scan_dr(41, 41'd0, dout);
        chk("cap_after_dmireset", dout, {7'h10, 32'h12345678, 2'd0});

        scan_dr(41, 41'h4000000001, dout);
        accept();
        respond(32'hDEADBEEF, DTM_ERR);
        scan_dr(41, 41'd0, dout);
        chk("cap_err", dout, {7'h10, 32'hDEADBEEF, 2'd2});
        write_ir(5'h10, irc);
        scan_dr(32, 41'h10000, dout);
        chk("dtmcs_err", dout, 64'h1871);
        scan_dr(32, 41'd0, dout);
        chk("dtmcs_clean", dout, 64'h1071);

        write_ir(5'h11, irc);
        scan_dr(41, 41'h4000000001, dout);
        accept();
        chk("abort_pre_wait", {63'd0, dmi_bus.resp_ready}, 64'd1);
        write_ir(5'h10, irc);
        scan_dr(32, 41'h20000, dout);
        chk("hardreset_pulse", clr_cnt, 64'd1);
        chk("hardreset_idle", {62'd0, dmi_bus.resp_ready, dmi_bus.req_valid}, 64'd0);
        write_ir(5'h11, irc);
        scan_dr(41, 41'd0, dout);
        chk("cap_after_abort", dout, {7'h10, 32'h0, 2'd0});

        write_ir(5'h1F, irc);
        scan_dr(8, 41'hA5, dout);
        chk("bypass", dout, 64'h4A);

        write_ir(5'h11, irc);
        scan_dr(41, 41'h4000000001, dout);
        accept();
        tap_reset();
        chk("tlr_keeps_wait", {63'd0, dmi_bus.resp_ready}, 64'd1);
        respond(32'h0, DTM_SUCCESS);
        chk("tlr_resp_done", {63'd0, dmi_bus.resp_ready}, 64'd0);
        scan_dr(32, 41'd0, dout);
        chk("idcode_after_tlr", dout, 64'h0DB3);

        write_ir(5'h11, irc);
        scan_dr(41, 41'h4000000001, dout);
        chk("pre_rst_valid", {63'd0, dmi_bus.req_valid}, 64'd1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_drops_valid", {63'd0, dmi_bus.req_valid}, 64'd0);
        chk("rst_drops_ready", {63'd0, dmi_bus.resp_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("total_reqs", req_cnt, 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
